// File: rtl/simon_pkg.sv
// ---------------------------------------------------------------------------
// simon_pkg
// Shared definitions for the Simon pattern player: command op codes, color
// codes, the player state enum and a small constant helper.
// ---------------------------------------------------------------------------
package simon_pkg;

    // Command op codes carried on cmd_op
    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_PLAY  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    // Color codes carried on cmd_color / out_color
    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] BLUE   = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] YELLOW = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } player_state_t;

    // Larger of two integers, used to size the shared ON/GAP timer
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/simon_pattern_player_color_buffer.sv
// ---------------------------------------------------------------------------
// color_buffer
// DEPTH x 2-bit register array holding the stored Simon pattern.
// Ports:
//   i_clock     system clock
//   i_wr_en     write strobe for the single synchronous write port
//   i_wr_addr   write index
//   i_wr_color  color written at i_wr_addr
//   i_rd_addr   read index (combinational read)
//   o_rd_color  color stored at i_rd_addr
// ---------------------------------------------------------------------------
module color_buffer #(
    parameter int DEPTH = 32
) (
    input  logic                     i_clock,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [1:0]               i_wr_color,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [1:0]               o_rd_color
);

    logic [1:0] r_mem [DEPTH];

    // NOTE: the storage has no reset; entries beyond count are never read,
    // so clearing them would only cost reset routing.
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_color;
        end
    end

    assign o_rd_color = r_mem[i_rd_addr];

endmodule

// File: rtl/simon_pattern_player.sv
// ---------------------------------------------------------------------------
// simon_pattern_player
// Plays back a stored Simon color pattern as one-cycle on/off strobes toward
// the LED and audio drivers, timing each flash and the dark gap after it.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   cmd_valid             command strobe, one command per asserted cycle
//   cmd_op, cmd_color     command op code and PUSH color
//   busy                  high while a pattern is playing
//   count, full           number of stored colors, count == DEPTH
//   done                  one-cycle pulse when playback ends or is aborted
//   led_strobe            one-cycle write strobe to the LED driver
//   audio_strobe          one-cycle write strobe to the audio driver
//   out_color, out_on     color and on/off value qualified by the strobes
// ---------------------------------------------------------------------------
module simon_pattern_player
    import simon_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int GAP_CYCLES = 12_500_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    input  logic [1:0]             cmd_op,
    input  logic [1:0]             cmd_color,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   done,
    output logic                   led_strobe,
    output logic                   audio_strobe,
    output logic [1:0]             out_color,
    output logic                   out_on
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXC = max_int(ON_CYCLES, GAP_CYCLES);
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    // Timer counts down from N-1 to 0, so a phase lasts exactly N cycles
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

    player_state_t  r_state;
    logic [AW-1:0]  r_idx;
    logic [CW-1:0]  r_count;
    logic [TW-1:0]  r_timer;
    logic           r_busy;
    logic           r_done;
    logic           r_strobe;
    logic [1:0]     r_color;
    logic           r_on;

    logic           w_full;
    logic           w_push;
    logic           w_abort;
    logic           w_last;
    logic [AW-1:0]  w_rd_addr;
    logic [1:0]     w_rd_color;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = cmd_valid && (cmd_op == OP_PUSH) && (r_state == IDLE) && !w_full;
    assign w_abort = cmd_valid && (cmd_op == OP_ABORT);
    assign w_last  = ((CW'(r_idx) + CW'(1)) == r_count);

    // The buffer is only read when a new on-strobe is launched: index 0 from
    // IDLE, or the next index at GAP expiry. Off-strobes reuse r_color.
    assign w_rd_addr = (r_state == GAP) ? (r_idx + AW'(1)) : '0;

    color_buffer #(
        .DEPTH (DEPTH)
    ) u_color_buffer (
        .i_clock    (clock),
        .i_wr_en    (w_push),
        .i_wr_addr  (r_count[AW-1:0]),
        .i_wr_color (cmd_color),
        .i_rd_addr  (w_rd_addr),
        .o_rd_color (w_rd_color)
    );

    // NOTE: all state here is written with non-blocking assignments so every
    // register samples pre-edge values, whatever the statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_count  <= '0;
            r_timer  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_strobe <= 1'b0;
            r_color  <= 2'b00;
            r_on     <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_strobe <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_PUSH: begin
                                if (!w_full) r_count <= r_count + CW'(1);
                            end
                            OP_CLEAR: r_count <= '0;
                            OP_PLAY: begin
                                if (r_count != '0) begin
                                    r_state  <= ON;
                                    r_busy   <= 1'b1;
                                    r_idx    <= '0;
                                    r_timer  <= ON_LOAD;
                                    r_strobe <= 1'b1;
                                    r_color  <= w_rd_color;
                                    r_on     <= 1'b1;
                                end else begin
                                    r_done <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ON: begin
                    if (w_abort) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_strobe <= 1'b1;
                        r_on     <= 1'b0;
                    end else if (r_timer == '0) begin
                        r_state  <= GAP;
                        r_timer  <= GAP_LOAD;
                        r_strobe <= 1'b1;
                        r_on     <= 1'b0;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                GAP: begin
                    if (w_abort || ((r_timer == '0) && w_last)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_timer == '0) begin
                        r_state  <= ON;
                        r_idx    <= r_idx + AW'(1);
                        r_timer  <= ON_LOAD;
                        r_strobe <= 1'b1;
                        r_color  <= w_rd_color;
                        r_on     <= 1'b1;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign count        = r_count;
    assign full         = w_full;
    assign done         = r_done;
    assign led_strobe   = r_strobe;
    assign audio_strobe = r_strobe;
    assign out_color    = r_color;
    assign out_on       = r_on;

endmodule

// File: tb/tb_simon_pattern_player.sv
// ---------------------------------------------------------------------------
// tb_simon_pattern_player
// Self-checking bench: directed scenarios plus random commands, compared each
// cycle against a schedule model. The model keeps the pattern in a queue and
// derives every strobe and done time arithmetically from the PLAY edge:
// color i turns on at P + i*(ON+GAP), off ON cycles later, and done lands at
// P + n*(ON+GAP).
// ---------------------------------------------------------------------------
module tb_simon_pattern_player;
    import simon_pkg::*;

    localparam int DEPTH = 4;
    localparam int ON_C  = 4;
    localparam int GAP_C = 2;
    localparam int PER   = ON_C + GAP_C;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [1:0] cmd_color;
    logic       busy;
    logic [2:0] count;
    logic       full;
    logic       done;
    logic       led_strobe;
    logic       audio_strobe;
    logic [1:0] out_color;
    logic       out_on;

    always #5 clock = ~clock;

    simon_pattern_player #(
        .DEPTH      (DEPTH),
        .ON_CYCLES  (ON_C),
        .GAP_CYCLES (GAP_C)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_color    (cmd_color),
        .busy         (busy),
        .count        (count),
        .full         (full),
        .done         (done),
        .led_strobe   (led_strobe),
        .audio_strobe (audio_strobe),
        .out_color    (out_color),
        .out_on       (out_on)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    logic [1:0] q[$];      // stored colors
    logic [1:0] pat[$];    // pattern snapshot being played
    bit         playing = 1'b0;
    int         p_start = 0;

    bit         e_busy, e_done, e_strobe, e_on;
    logic [1:0] e_color;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance the model by one clock edge (edge number cyc)
    task automatic model_edge(input bit v, input logic [1:0] op, input logic [1:0] col);
        int rel;
        e_busy   = 1'b0;
        e_done   = 1'b0;
        e_strobe = 1'b0;
        e_on     = 1'b0;
        e_color  = 2'b00;
        if (!playing) begin
            if (v) begin
                case (op)
                    OP_PUSH:  if (q.size() < DEPTH) q.push_back(col);
                    OP_CLEAR: q.delete();
                    OP_PLAY: begin
                        if (q.size() > 0) begin
                            pat     = q;
                            playing = 1'b1;
                            p_start = cyc;
                        end else begin
                            e_done = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (v && op == OP_ABORT) begin
            rel     = cyc - 1 - p_start;
            playing = 1'b0;
            e_done  = 1'b1;
            if (rel % PER < ON_C) begin
                e_strobe = 1'b1;
                e_on     = 1'b0;
                e_color  = pat[rel / PER];
            end
        end
        if (playing) begin
            rel = cyc - p_start;
            if (rel < pat.size() * PER) begin
                e_busy = 1'b1;
                if (rel % PER == 0) begin
                    e_strobe = 1'b1;
                    e_on     = 1'b1;
                    e_color  = pat[rel / PER];
                end else if (rel % PER == ON_C) begin
                    e_strobe = 1'b1;
                    e_on     = 1'b0;
                    e_color  = pat[rel / PER];
                end
            end else begin
                e_done  = 1'b1;
                playing = 1'b0;
            end
        end
    endtask

    task automatic compare_outputs();
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("led_strobe", led_strobe, e_strobe);
        check("audio_strobe", audio_strobe, e_strobe);
        check("count", count, q.size());
        check("full", full, q.size() == DEPTH);
        if (e_strobe) begin
            check("out_color", out_color, e_color);
            check("out_on", out_on, e_on);
        end
    endtask

    // One clock with the given command; inputs change on the falling edge
    task automatic tick(input bit v, input logic [1:0] op, input logic [1:0] col);
        cmd_valid = v;
        cmd_op    = op;
        cmd_color = col;
        @(posedge clock);
        cyc++;
        model_edge(v, op, col);
        @(negedge clock);
        compare_outputs();
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, OP_PUSH, RED);
    endtask

    // Reset for one edge, optionally with a simultaneous PUSH that must lose
    task automatic do_reset(input bit with_cmd);
        reset     = 1'b1;
        cmd_valid = with_cmd;
        cmd_op    = OP_PUSH;
        cmd_color = YELLOW;
        @(posedge clock);
        cyc++;
        q.delete();
        playing = 1'b0;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_led_strobe", led_strobe, 0);
        check("rst_audio_strobe", audio_strobe, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_out_color", out_color, 0);
        check("rst_out_on", out_on, 0);
        reset     = 1'b0;
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_PUSH;
        cmd_color = RED;

        do_reset(1'b1);
        idle(1);

        // Three colors, full playback
        tick(1'b1, OP_PUSH, RED);
        tick(1'b1, OP_PUSH, GREEN);
        tick(1'b1, OP_PUSH, BLUE);
        tick(1'b1, OP_PLAY, RED);
        idle(3 * PER + 2);

        // Five pushes: only four stored, replay shows four
        tick(1'b1, OP_CLEAR, RED);
        tick(1'b1, OP_PUSH, YELLOW);
        tick(1'b1, OP_PUSH, BLUE);
        tick(1'b1, OP_PUSH, GREEN);
        tick(1'b1, OP_PUSH, RED);
        tick(1'b1, OP_PUSH, BLUE);
        tick(1'b1, OP_PLAY, RED);
        idle(4 * PER + 2);

        // PLAY on an empty buffer
        tick(1'b1, OP_CLEAR, RED);
        tick(1'b1, OP_PLAY, RED);
        idle(3);

        // ABORT during the second ON, then replay from index 0
        tick(1'b1, OP_PUSH, BLUE);
        tick(1'b1, OP_PUSH, GREEN);
        tick(1'b1, OP_PUSH, YELLOW);
        tick(1'b1, OP_PLAY, RED);
        idle(PER + 1);
        tick(1'b1, OP_ABORT, RED);
        idle(2);
        tick(1'b1, OP_ABORT, RED);      // ignored in IDLE
        tick(1'b1, OP_PLAY, RED);
        idle(PER + ON_C + 1);
        tick(1'b1, OP_ABORT, RED);      // abort in GAP: no strobe
        idle(2);

        // PUSH / CLEAR / PLAY while busy are ignored
        tick(1'b1, OP_CLEAR, RED);
        tick(1'b1, OP_PUSH, GREEN);
        tick(1'b1, OP_PUSH, RED);
        tick(1'b1, OP_PLAY, RED);
        tick(1'b1, OP_PUSH, YELLOW);
        tick(1'b1, OP_CLEAR, RED);
        tick(1'b1, OP_PLAY, RED);
        idle(2 * PER);
        tick(1'b1, OP_CLEAR, RED);

        // Reset during GAP
        tick(1'b1, OP_PUSH, YELLOW);
        tick(1'b1, OP_PLAY, RED);
        idle(ON_C);
        do_reset(1'b0);
        idle(3);

        // Random command stream
        for (int i = 0; i < 600; i++) begin
            logic [1:0] r_op;
            logic [1:0] r_col;
            bit         r_v;
            r_v   = ($urandom_range(0, 99) < 40);
            r_op  = 2'($urandom_range(0, 3));
            r_col = 2'($urandom_range(0, 3));
            if (r_op == OP_ABORT && $urandom_range(0, 3) != 0) r_op = OP_PUSH;
            tick(r_v, r_op, r_col);
        end
        idle(DEPTH * PER + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
